// File: rtl/mopshub_pkg.sv
// Shared constants and state type for the MOPSHUB receive-path arbiter.
package mopshub_pkg;

  localparam int N_BUS       = 32;
  localparam int SEL_W       = $clog2(N_BUS);
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rec_arb_state_t;

endpackage

// File: rtl/mopshub_rr_pick.sv
// Combinational round-robin picker: scans the eligible vector from 'start'
// upward, wrapping from n_buses back to 0, and returns the first hit.
module mopshub_rr_pick
  import mopshub_pkg::*;
#(
  parameter int BUS_CNT = N_BUS,
  parameter int IDX_W   = SEL_W
) (
  input  logic [BUS_CNT-1:0] eligible,
  input  logic [IDX_W-1:0]   start,
  input  logic [IDX_W-1:0]   n_buses,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  // One extra bit so start+k never overflows before the wrap correction.
  localparam int XW = IDX_W + 1;

  logic [XW-1:0] cand;

  // Walk at most n_buses+1 positions; start is always <= n_buses so one subtraction wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < BUS_CNT; k++) begin
      cand = {1'b0, start} + XW'(k);
      if (cand > {1'b0, n_buses}) begin
        cand = cand - ({1'b0, n_buses} + XW'(1));
      end
      if (!found && (XW'(k) <= {1'b0, n_buses}) && eligible[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mopshub_rec_arbiter.sv
// Round-robin arbiter sharing the CAN-receive to e-link uplink among the bus
// controllers: grants one bus, starts the uplink writer, waits for completion
// or timeout, then acknowledges the bus so it can drop its request.
module mopshub_rec_arbiter #(
  parameter int N_BUS   = mopshub_pkg::N_BUS,
  parameter int SEL_W   = mopshub_pkg::SEL_W,
  parameter int TIMEOUT = 4000
) (
  input  logic                                clk_40_m,
  input  logic                                rst,
  input  logic [SEL_W-1:0]                    n_buses,
  input  logic [N_BUS-1:0]                    bus_mask,
  input  logic [N_BUS-1:0]                    req,
  input  logic                                rec_done,
  output logic [N_BUS-1:0]                    grant,
  output logic [SEL_W-1:0]                    can_rec_select,
  output logic                                rec_start,
  output logic [N_BUS-1:0]                    rec_ack,
  output logic                                timeout_err,
  output logic                                busy,
  output logic [mopshub_pkg::FRAME_CNT_W-1:0] frame_cnt
);

  import mopshub_pkg::*;

  // The timer is cleared on WAIT entry, so at the edge where it would reach
  // TIMEOUT-1 it still reads TIMEOUT-2; that edge is the abandon point.
  localparam int              TMR_W      = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(TIMEOUT - 2);
  localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TIMEOUT - 1);
  localparam logic [N_BUS-1:0] ONE_HOT0   = N_BUS'(1);

  rec_arb_state_t   state;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] winner;
  logic [TMR_W-1:0] timer;
  logic [N_BUS-1:0] eligible;
  logic             found;

  // A bus competes only if it requests, is enabled and lies within n_buses.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_BUS; i++) begin
      eligible[i] = req[i] & bus_mask[i] & (SEL_W'(i) <= n_buses);
    end
  end

  assign start = (last >= n_buses) ? '0 : last + SEL_W'(1);

  mopshub_rr_pick #(
    .BUS_CNT (N_BUS),
    .IDX_W   (SEL_W)
  ) u_pick (
    .eligible (eligible),
    .start    (start),
    .n_buses  (n_buses),
    .winner   (winner),
    .found    (found)
  );

  // Arbitration FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state          <= IDLE;
      grant          <= '0;
      can_rec_select <= '0;
      last           <= '1;
      rec_start      <= 1'b0;
      rec_ack        <= '0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
      frame_cnt      <= '0;
      timer          <= '0;
    end else begin
      rec_start   <= 1'b0;
      rec_ack     <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state          <= WAIT;
            can_rec_select <= winner;
            grant          <= ONE_HOT0 << winner;
            rec_start      <= 1'b1;
            busy           <= 1'b1;
            timer          <= '0;
          end
        end
        WAIT: begin
          if (rec_done) begin
            state     <= ACK;
            rec_ack   <= ONE_HOT0 << can_rec_select;
            grant     <= '0;
            last      <= can_rec_select;
            frame_cnt <= frame_cnt + 1'b1;
          end else if (timer == TMR_EXPIRE) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            grant       <= '0;
            last        <= can_rec_select;
            busy        <= 1'b0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TMR_W'(1);
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mopshub_rec_arbiter.sv
// Scoreboard bench for mopshub_rec_arbiter: stimulus queues expected grants,
// acks and timeouts; a monitor pops and compares whenever the DUT pulses.
module tb_mopshub_rec_arbiter;

  localparam int N_BUS   = 32;
  localparam int SEL_W   = 5;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic             clk_40_m = 1'b0;
  logic             rst;
  logic [SEL_W-1:0] n_buses;
  logic [N_BUS-1:0] bus_mask;
  logic [N_BUS-1:0] req;
  logic             rec_done;
  logic [N_BUS-1:0] grant;
  logic [SEL_W-1:0] can_rec_select;
  logic             rec_start;
  logic [N_BUS-1:0] rec_ack;
  logic             timeout_err;
  logic             busy;
  logic [15:0]      frame_cnt;

  int checks     = 0;
  int failures   = 0;
  int writer_lat = -1;
  int exp_frames = 0;
  int cyc        = 0;

  typedef struct { int sel; int period; }          start_exp_t;
  typedef struct { int sel; int frame; int delta; } ack_exp_t;
  typedef struct { int sel; int delta; }            tmo_exp_t;

  start_exp_t start_q[$];
  ack_exp_t   ack_q[$];
  tmo_exp_t   tmo_q[$];

  mopshub_rec_arbiter #(
    .N_BUS   (N_BUS),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_40_m       (clk_40_m),
    .rst            (rst),
    .n_buses        (n_buses),
    .bus_mask       (bus_mask),
    .req            (req),
    .rec_done       (rec_done),
    .grant          (grant),
    .can_rec_select (can_rec_select),
    .rec_start      (rec_start),
    .rec_ack        (rec_ack),
    .timeout_err    (timeout_err),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  initial forever #12 clk_40_m = ~clk_40_m;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectStart(input int sel, input int period);
    start_exp_t e;
    e.sel = sel; e.period = period;
    start_q.push_back(e);
  endtask

  task automatic expectAck(input int sel, input int delta);
    ack_exp_t e;
    exp_frames++;
    e.sel = sel; e.frame = exp_frames; e.delta = delta;
    ack_q.push_back(e);
  endtask

  task automatic expectTimeout(input int sel, input int delta);
    tmo_exp_t e;
    e.sel = sel; e.delta = delta;
    tmo_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] r, input logic [31:0] m, input logic [4:0] nb);
    @(negedge clk_40_m);
    req      = r;
    bus_mask = m;
    n_buses  = nb;
  endtask

  task automatic waitStarts(input int target, input int budget, input string name);
    int n = 0;
    int t = 0;
    while (n < target && t < budget) begin
      @(negedge clk_40_m);
      t++;
      if (rec_start === 1'b1) n++;
    end
    if (n < target) checkOutput(name, n, target);
  endtask

  task automatic waitAck(input int budget, input string name);
    int t = 0;
    do begin
      @(negedge clk_40_m);
      t++;
    end while (!(rec_ack != '0) && t < budget);
    if (!(rec_ack != '0)) checkOutput(name, 32'(rec_ack != '0), 1);
  endtask

  task automatic waitTimeoutErr(input int budget, input string name);
    int t = 0;
    do begin
      @(negedge clk_40_m);
      t++;
    end while (timeout_err !== 1'b1 && t < budget);
    if (timeout_err !== 1'b1) checkOutput(name, 32'(timeout_err), 1);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int t = 0;
    do begin
      @(negedge clk_40_m);
      t++;
    end while (busy !== 1'b0 && t < budget);
    if (busy !== 1'b0) checkOutput(name, 32'(busy), 0);
    repeat (2) @(negedge clk_40_m);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_sel"}, 32'(can_rec_select), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_start"}, 32'(rec_start), 0);
    checkOutput({tag, "_ack"}, rec_ack, 0);
    checkOutput({tag, "_tmo"}, 32'(timeout_err), 0);
    checkOutput({tag, "_frames"}, 32'(frame_cnt), 0);
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk_40_m);
    rst = 1'b0;
    @(negedge clk_40_m);
    exp_frames = 0;
    checkResetState(tag);
    rst = 1'b1;
  endtask

  // Uplink writer model: answers each rec_start with rec_done after writer_lat cycles.
  initial begin : writer
    rec_done = 1'b0;
    forever begin
      @(negedge clk_40_m);
      if (rec_start === 1'b1 && writer_lat >= 0) begin
        repeat (writer_lat) @(negedge clk_40_m);
        rec_done = 1'b1;
        @(negedge clk_40_m);
        rec_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses start, ack or timeout.
  initial begin : monitor
    int         last_start;
    start_exp_t s;
    ack_exp_t   a;
    tmo_exp_t   m;
    last_start = 0;
    forever begin
      @(negedge clk_40_m);
      cyc++;
      if (rec_start === 1'b1) begin
        if (start_q.size() == 0) begin
          checkOutput("unexpected_start", 32'(rec_start), 0);
        end else begin
          s = start_q.pop_front();
          checkOutput("grant_sel", 32'(can_rec_select), s.sel);
          checkOutput("grant_onehot", grant, 32'd1 << s.sel);
          checkOutput("grant_busy", 32'(busy), 1);
          if (s.period >= 0) checkOutput("grant_period", cyc - last_start, s.period);
        end
        last_start = cyc;
      end
      if (rec_ack != '0) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected_ack", rec_ack, 0);
        end else begin
          a = ack_q.pop_front();
          checkOutput("ack_onehot", rec_ack, 32'd1 << a.sel);
          checkOutput("ack_grant_clear", grant, 0);
          checkOutput("ack_frame_cnt", 32'(frame_cnt), a.frame);
          if (a.delta >= 0) checkOutput("ack_latency", cyc - last_start, a.delta);
        end
      end
      if (timeout_err === 1'b1) begin
        if (tmo_q.size() == 0) begin
          checkOutput("unexpected_timeout", 32'(timeout_err), 0);
        end else begin
          m = tmo_q.pop_front();
          checkOutput("tmo_sel", 32'(can_rec_select), m.sel);
          checkOutput("tmo_grant_clear", grant, 0);
          checkOutput("tmo_latency", cyc - last_start, m.delta);
        end
      end
    end
  end

  // Hard stop in case some wait never returns.
  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin : stimulus
    int seq_a[9];
    int seq_b[8];
    seq_a = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    seq_b = '{3, 4, 5, 6, 7, 0, 1, 3};

    rst      = 1'b0;
    req      = '0;
    bus_mask = ALL;
    n_buses  = 5'd31;
    repeat (3) @(negedge clk_40_m);
    checkResetState("por");
    rst = 1'b1;

    $display("[TB] single request on bus 4");
    writer_lat = 5;
    expectStart(4, -1);
    expectAck(4, 6);
    applyStimulus(32'h0000_0010, ALL, 5'd31);
    waitAck(40, "t1_ack_wait");
    req = '0;
    waitIdle(20, "t1_idle");

    $display("[TB] all 32 buses requesting");
    pulseReset("t2_reset");
    for (int i = 0; i < 32; i++) begin
      expectStart(i, (i == 0) ? -1 : 8);
      expectAck(i, 6);
    end
    expectStart(0, 8);
    expectAck(0, 6);
    applyStimulus(ALL, ALL, 5'd31);
    waitStarts(33, 33 * 8 + 20, "t2_start_wait");
    req = '0;
    waitIdle(30, "t2_idle");

    $display("[TB] n_buses=7, then bus 2 masked");
    for (int i = 0; i < 9; i++) begin
      expectStart(seq_a[i], (i == 0) ? -1 : 8);
      expectAck(seq_a[i], 6);
    end
    applyStimulus(ALL, ALL, 5'd7);
    waitStarts(9, 9 * 8 + 20, "t3a_start_wait");
    req = '0;
    waitIdle(30, "t3a_idle");
    for (int i = 0; i < 8; i++) begin
      expectStart(seq_b[i], (i == 0) ? -1 : 8);
      expectAck(seq_b[i], 6);
    end
    applyStimulus(ALL, 32'hFFFF_FFFB, 5'd7);
    waitStarts(8, 8 * 8 + 20, "t3b_start_wait");
    req = '0;
    waitIdle(30, "t3b_idle");

    $display("[TB] writer silent, expect timeout then next bus");
    writer_lat = -1;
    expectStart(2, -1);
    expectTimeout(2, 15);
    expectStart(3, 16);
    expectAck(3, 6);
    applyStimulus(32'h0000_000C, ALL, 5'd7);
    waitTimeoutErr(40, "t4_tmo_wait");
    req        = 32'h0000_0008;
    writer_lat = 5;
    waitAck(40, "t4_ack_wait");
    req = '0;
    waitIdle(20, "t4_idle");

    $display("[TB] rec_done on the timeout cycle");
    writer_lat = 14;
    expectStart(5, -1);
    expectAck(5, 15);
    applyStimulus(32'h0000_0020, ALL, 5'd7);
    waitAck(40, "t5_ack_wait");
    req = '0;
    waitIdle(20, "t5_idle");

    $display("[TB] reset during WAIT");
    writer_lat = -1;
    expectStart(6, -1);
    applyStimulus(32'h0000_0048, ALL, 5'd7);
    waitStarts(1, 10, "t6_start_wait");
    repeat (3) @(negedge clk_40_m);
    rst = 1'b0;
    @(negedge clk_40_m);
    exp_frames = 0;
    checkResetState("t6_reset");
    expectStart(3, -1);
    expectAck(3, 6);
    writer_lat = 5;
    rst        = 1'b1;
    waitAck(40, "t6_ack_wait");
    req = '0;
    waitIdle(20, "t6_idle");

    repeat (5) @(negedge clk_40_m);
    checkOutput("start_q_left", start_q.size(), 0);
    checkOutput("ack_q_left", ack_q.size(), 0);
    checkOutput("tmo_q_left", tmo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
